hex_word_entry: RTL and testbench
=================================

# hex_word_entry

Front-panel input block for the PDA board, the input counterpart of the eight-digit hex display path. The user sets a hex digit on four slide switches and presses a digit button; the block shifts the nibble into a 32-bit entry word shown on the HEX digits. A commit button writes the word into CPU data memory through a valid/ready write port at an auto-incrementing word address. A clear button discards the current entry. All three buttons are debounced inside the block.

## Interface

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a button level is accepted (1 ms at 50 MHz).
- BASE_ADDR, 32'h0000_0000: first write address after reset; word aligned.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- sw_nibble  in  4  hex digit from the switches; sampled only on an accepted digit press.
- btn_digit  in  1  raw push-button, active-high; appends a nibble.
- btn_commit  in  1  raw push-button, active-high; writes the entry word.
- btn_clear  in  1  raw push-button, active-high; clears the entry.
- entry_word  out  32  current entry, for the HEX0..HEX7 drivers.
- digit_count  out  4  number of nibbles entered, 0..8.
- wr_valid  out  1  write request.
- wr_ready  in  1  memory accepts the write.
- wr_addr  out  32  write address.
- wr_data  out  32  write data.
- busy  out  1  high while in S_WRITE.

## Operation

- Each button passes through a button_debounce instance:
  - 2-FF synchronizer.
  - Counter of consecutive cycles in which the synchronized input differs from the debounced level. The counter clears on any equal cycle.
  - When the counter reaches DEBOUNCE_CYCLES, the level flips and the counter clears.
  - A registered one-cycle pulse is emitted on each rising edge of the debounced level.
- FSM, two states:
  - S_ENTRY (reset state):
    - Digit pulse: entry_word <= {entry_word[27:0], sw_nibble}. digit_count increments and saturates at 8; past 8 digits the oldest nibble falls off.
    - Clear pulse: entry_word <= 0, digit_count <= 0.
    - Commit pulse with digit_count != 0: latch wr_data <= entry_word, go to S_WRITE.
    - Commit pulse with digit_count == 0: ignored.
  - S_WRITE:
    - wr_valid = 1. wr_addr and wr_data are held stable until the transfer.
    - Transfer happens at the edge where wr_valid && wr_ready.
    - On transfer: wr_addr += 4 (wraps modulo 2^32), entry_word <= 0, digit_count <= 0, return to S_ENTRY.
    - All button pulses in S_WRITE are dropped, including clear; wr_valid never deasserts before the transfer. Debouncers keep running.
- Simultaneous pulses in the same cycle in S_ENTRY resolve by priority commit > clear > digit; the lower-priority pulses are dropped.
- Reset values: entry_word = 0, digit_count = 0, wr_valid = 0, busy = 0, wr_data = 0, wr_addr = BASE_ADDR. All debouncer levels, counters and pulses = 0. Reset mid-write abandons the request with no transfer.

## Timing

- Button press to pulse: 2 synchronizer cycles + DEBOUNCE_CYCLES + 1 pulse register cycle.
- Pulse to entry_word/digit_count update: visible the cycle after the pulse.
- Commit pulse to wr_valid high: 1 cycle. Any hold time is allowed on wr_ready; a transfer can occur on the first valid cycle.
- Transfer to wr_valid low and entry cleared: next cycle. Minimum one S_ENTRY cycle between writes.
- All outputs are registered; there is no combinational path from wr_ready to any output.
- A bounce shorter than DEBOUNCE_CYCLES yields no pulse. A held button yields exactly one pulse, and no further pulse until release is accepted.

## Structure

- Package pda_io_pkg: WORD_W = 32, NIBBLES = 8, ADDR_STEP = 4, and the state enum entry_state_t {S_ENTRY, S_WRITE}.
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES; ports clk, reset, btn_raw, level, rise_pulse), instantiated three times.
- Top-level integration: entry_word feeds the existing Display7Seg instances; the wr_* port joins the PDA data-memory write arbiter.

## Test plan

All scenarios use DEBOUNCE_CYCLES = 4.

- Reset then idle: entry_word = 0, digit_count = 0, wr_valid = 0, wr_addr = BASE_ADDR.
- Press digit with switches at A, B, C, D (clean presses): entry_word = 32'h0000_ABCD, digit_count = 4. Each update lands exactly 2 + 4 + 1 + 1 cycles after its press edge.
- Enter 1..9 (nine digits): entry_word = 32'h2345_6789, digit_count = 8. Then clear: both 0.
- Bouncing digit input toggling every 2 cycles for 20 cycles, then stable high: exactly one nibble is appended.
- Enter 32'h0000_00FF and commit, with wr_ready low for 5 cycles then high: wr_valid stays high and wr_data stays 32'h0000_00FF for 6 cycles. A clear press during the wait is ignored. The transfer goes to BASE_ADDR. A second word then goes to BASE_ADDR + 4.
- Commit with digit_count = 0: no wr_valid. Commit and digit pulses in the same cycle: the write occurs and the nibble is dropped. Reset asserted during S_WRITE: wr_valid drops immediately and wr_addr = BASE_ADDR.

Source files
------------

// File: rtl/pda_io_pkg.sv
// Shared constants and state type for the PDA front-panel I/O blocks.
package pda_io_pkg;
  localparam int WORD_W    = 32;
  localparam int NIBBLES   = 8;
  localparam int ADDR_STEP = 4;
  localparam int COUNT_W   = 4;

  typedef enum logic {
    S_ENTRY,
    S_WRITE
  } entry_state_t;
endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, and a
// registered one-cycle pulse on each rising edge of the debounced level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      level      <= 1'b0;
      level_d    <= 1'b0;
      rise_pulse <= 1'b0;
      cnt        <= '0;
    end else begin
      sync1      <= btn_raw;
      sync2      <= sync1;
      level_d    <= level;
      rise_pulse <= level & ~level_d;
      // The flip happens on the DEBOUNCE_CYCLES-th consecutive differing cycle.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/hex_word_entry.sv
// Front-panel hex word entry: debounced digit/commit/clear buttons build a
// 32-bit word and write it to data memory over a valid/ready port.
module hex_word_entry
  import pda_io_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  sw_nibble,
  input  logic        btn_digit,
  input  logic        btn_commit,
  input  logic        btn_clear,
  output logic [31:0] entry_word,
  output logic [3:0]  digit_count,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy
);
  // Write handshake: wr_valid rises the cycle after an accepted commit and
  // stays high with wr_addr/wr_data frozen until the edge where
  // wr_valid && wr_ready; that edge is the transfer.

  entry_state_t state, state_next;
  logic [WORD_W-1:0]  entry_next;
  logic [COUNT_W-1:0] count_next;
  logic [WORD_W-1:0]  addr_next;
  logic [WORD_W-1:0]  data_next;
  logic               digit_pulse;
  logic               commit_pulse;
  logic               clear_pulse;
  logic [2:0]         unused_levels;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_digit (
    .clk(clk), .reset(reset), .btn_raw(btn_digit),
    .level(unused_levels[0]), .rise_pulse(digit_pulse)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_commit (
    .clk(clk), .reset(reset), .btn_raw(btn_commit),
    .level(unused_levels[1]), .rise_pulse(commit_pulse)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .reset(reset), .btn_raw(btn_clear),
    .level(unused_levels[2]), .rise_pulse(clear_pulse)
  );

  always_comb begin
    state_next = state;
    entry_next = entry_word;
    count_next = digit_count;
    addr_next  = wr_addr;
    data_next  = wr_data;
    case (state)
      S_ENTRY: begin
        // A commit pulse always wins the cycle, even when it is ignored.
        if (commit_pulse) begin
          if (digit_count != '0) begin
            data_next  = entry_word;
            state_next = S_WRITE;
          end
        end else if (clear_pulse) begin
          entry_next = '0;
          count_next = '0;
        end else if (digit_pulse) begin
          entry_next = {entry_word[WORD_W-5:0], sw_nibble};
          if (digit_count != COUNT_W'(NIBBLES)) begin
            count_next = digit_count + 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (wr_valid && wr_ready) begin
          addr_next  = wr_addr + WORD_W'(ADDR_STEP);
          entry_next = '0;
          count_next = '0;
          state_next = S_ENTRY;
        end
      end
      default: state_next = S_ENTRY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_ENTRY;
      entry_word  <= '0;
      digit_count <= '0;
      wr_addr     <= BASE_ADDR;
      wr_data     <= '0;
      wr_valid    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      entry_word  <= entry_next;
      digit_count <= count_next;
      wr_addr     <= addr_next;
      wr_data     <= data_next;
      wr_valid    <= (state_next == S_WRITE);
      busy        <= (state_next == S_WRITE);
    end
  end
endmodule

// File: tb/tb_hex_word_entry.sv
// Bench for hex_word_entry: directed scenarios plus a randomized phase checked
// against a word-level model of the entry register and the write port.
module tb_hex_word_entry;
  localparam int          DB   = 4;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        reset;
  logic [3:0]  sw_nibble;
  logic        btn_digit;
  logic        btn_commit;
  logic        btn_clear;
  logic [31:0] entry_word;
  logic [3:0]  digit_count;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;

  hex_word_entry #(.DEBOUNCE_CYCLES(DB), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .sw_nibble(sw_nibble),
    .btn_digit(btn_digit), .btn_commit(btn_commit), .btn_clear(btn_clear),
    .entry_word(entry_word), .digit_count(digit_count),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] m_entry;
  int          m_count;
  logic [31:0] m_addr;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_entry = 32'h0;
    m_count = 0;
    m_addr  = BASE;
  endtask

  task automatic model_digit(input logic [3:0] n);
    m_entry = 32'(m_entry * 16 + 32'(n));
    m_count = (m_count < 8) ? m_count + 1 : 8;
  endtask

  task automatic check_entry(input string tag);
    check({tag, "_entry"}, entry_word, m_entry);
    check({tag, "_count"}, 32'(digit_count), 32'(m_count));
  endtask

  // driver tasks
  task automatic press_digit(input logic [3:0] n);
    sw_nibble = n;
    btn_digit = 1'b1;
    cycles(7);
    check_entry("digit_before");
    model_digit(n);
    cycles(1);
    check_entry("digit_after");
    sw_nibble = 4'($urandom_range(0, 15));
    btn_digit = 1'b0;
    cycles(8);
  endtask

  task automatic press_clear();
    btn_clear = 1'b1;
    cycles(7);
    check_entry("clear_before");
    m_entry = 32'h0;
    m_count = 0;
    cycles(1);
    check_entry("clear_after");
    btn_clear = 1'b0;
    cycles(8);
  endtask

  task automatic commit_empty();
    btn_commit = 1'b1;
    cycles(8);
    check("empty_valid", 32'(wr_valid), 32'h0);
    btn_commit = 1'b0;
    cycles(8);
    check("empty_busy", 32'(busy), 32'h0);
    check_entry("empty");
  endtask

  // Commit the current word; wr_ready is held low for 'delay' valid cycles.
  task automatic commit_word(input int delay, input bit with_digit, input bit poke_clear);
    logic [63:0] got;
    logic [63:0] want;
    wr_ready   = (delay == 0);
    btn_commit = 1'b1;
    if (with_digit) begin
      sw_nibble = 4'($urandom_range(0, 15));
      btn_digit = 1'b1;
    end
    cycles(7);
    check("commit_early_valid", 32'(wr_valid), 32'h0);
    cycles(1);
    check("commit_valid", 32'(wr_valid), 32'h1);
    check("commit_busy", 32'(busy), 32'h1);
    check("commit_data", wr_data, m_entry);
    check("commit_addr", wr_addr, m_addr);
    check_entry("commit_hold");
    exp_q.push_back({m_addr, m_entry});
    btn_commit = 1'b0;
    btn_digit  = 1'b0;
    for (int i = 0; i < delay; i++) begin
      if (poke_clear && i == 1) btn_clear = 1'b1;
      if (poke_clear && i == 9) btn_clear = 1'b0;
      check("wait_valid", 32'(wr_valid), 32'h1);
      check("wait_data", wr_data, m_entry);
      check("wait_addr", wr_addr, m_addr);
      check_entry("wait");
      cycles(1);
    end
    wr_ready = 1'b1;
    check("last_valid", 32'(wr_valid), 32'h1);
    got = {wr_addr, wr_data};
    cycles(1);
    want = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
    check("xfer_addr", got[63:32], want[63:32]);
    check("xfer_data", got[31:0], want[31:0]);
    m_addr  = m_addr + 32'd4;
    m_entry = 32'h0;
    m_count = 0;
    check("post_valid", 32'(wr_valid), 32'h0);
    check("post_busy", 32'(busy), 32'h0);
    check("post_addr", wr_addr, m_addr);
    check_entry("post");
    wr_ready = 1'b0;
    btn_clear = 1'b0;
    cycles(8);
  endtask

  initial begin
    reset = 1'b1;
    sw_nibble = 4'h0;
    btn_digit = 1'b0;
    btn_commit = 1'b0;
    btn_clear = 1'b0;
    wr_ready = 1'b0;
    model_reset();
    cycles(3);
    check("rst_valid", 32'(wr_valid), 32'h0);
    check("rst_addr", wr_addr, BASE);
    check("rst_data", wr_data, 32'h0);
    check_entry("rst");
    reset = 1'b0;
    cycles(10);
    check("idle_valid", 32'(wr_valid), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_addr", wr_addr, BASE);
    check_entry("idle");

    // A, B, C, D
    press_digit(4'hA);
    press_digit(4'hB);
    press_digit(4'hC);
    press_digit(4'hD);
    check("abcd_word", entry_word, 32'h0000_ABCD);
    check("abcd_count", 32'(digit_count), 32'd4);
    press_clear();

    // nine digits: the oldest falls off and the count saturates
    for (int d = 1; d <= 9; d++) press_digit(4'(d));
    check("nine_word", entry_word, 32'h2345_6789);
    check("nine_count", 32'(digit_count), 32'd8);
    press_clear();
    check("clr_word", entry_word, 32'h0);

    // bouncing digit input, then a clean hold
    sw_nibble = 4'h5;
    for (int i = 0; i < 10; i++) begin
      btn_digit = (i % 2 == 0);
      cycles(2);
    end
    check_entry("bounce");
    btn_digit = 1'b1;
    cycles(10);
    model_digit(4'h5);
    check_entry("bounce_hold");
    btn_digit = 1'b0;
    cycles(8);
    check("bounce_count", 32'(digit_count), 32'd1);
    press_clear();

    // 0xFF, ready late by 5 cycles
    press_digit(4'hF);
    press_digit(4'hF);
    check("ff_word", entry_word, 32'h0000_00FF);
    commit_word(5, 1'b0, 1'b0);
    check("first_addr", wr_addr, BASE + 32'd4);

    // second write, clear pressed while waiting
    press_digit(4'hF);
    press_digit(4'hF);
    commit_word(14, 1'b0, 1'b1);
    check("second_addr", wr_addr, BASE + 32'd8);

    // empty commit; commit and digit together
    commit_empty();
    press_digit(4'h1);
    press_digit(4'h2);
    commit_word(0, 1'b1, 1'b0);

    // reset mid-write
    press_digit(4'h9);
    wr_ready = 1'b0;
    btn_commit = 1'b1;
    cycles(8);
    check("rw_valid", 32'(wr_valid), 32'h1);
    btn_commit = 1'b0;
    cycles(2);
    reset = 1'b1;
    #1;
    check("rw_valid_drop", 32'(wr_valid), 32'h0);
    check("rw_busy_drop", 32'(busy), 32'h0);
    check("rw_addr", wr_addr, BASE);
    model_reset();
    check_entry("rw");
    cycles(2);
    reset = 1'b0;
    cycles(10);

    // randomized operations
    for (int k = 0; k < 30; k++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        press_digit(4'($urandom_range(0, 15)));
      end else if (op == 6) begin
        press_clear();
      end else if (m_count != 0) begin
        commit_word($urandom_range(0, 6), ($urandom_range(0, 3) == 0), 1'b0);
      end else begin
        commit_empty();
      end
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
